// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue ahead of the register file write port.
// Merges ALU and load results, drains one entry per cycle, and forwards pending values to readers.
module regfile_writeback_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    input  logic [ADDR_WIDTH-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]   alu_data,
    output logic                    alu_ready,
    input  logic                    mem_valid,
    input  logic [ADDR_WIDTH-1:0]   mem_rd,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic                    mem_ready,
    output logic                    RegWrite,
    output logic [ADDR_WIDTH-1:0]   write_reg,
    output logic [DATA_WIDTH-1:0]   write_data,
    input  logic [ADDR_WIDTH-1:0]   rs1,
    input  logic [ADDR_WIDTH-1:0]   rs2,
    output logic                    fwd1_hit,
    output logic [DATA_WIDTH-1:0]   fwd1_data,
    output logic                    fwd2_hit,
    output logic [DATA_WIDTH-1:0]   fwd2_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] rd_mem_r   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic [CNT_W-1:0]      free_s;
    logic                  mem_push_s;
    logic                  alu_push_s;
    logic                  pop_s;
    logic [PTR_W-1:0]      alu_slot_s;
    logic [CNT_W-1:0]      push_cnt_s;

    // Readiness looks only at current occupancy; a same-cycle pop earns no credit.
    assign free_s     = CNT_W'(DEPTH) - count_r;
    assign mem_ready  = (free_s >= CNT_W'(1));
    assign alu_ready  = mem_valid ? (free_s >= CNT_W'(2)) : (free_s >= CNT_W'(1));

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_push_s = mem_valid && mem_ready && (mem_rd != '0);
    assign alu_push_s = alu_valid && alu_ready && (alu_rd != '0);
    assign pop_s      = (count_r != '0);
    assign alu_slot_s = tail_r + PTR_W'(mem_push_s);
    assign push_cnt_s = CNT_W'(mem_push_s) + CNT_W'(alu_push_s);
    assign count      = count_r;

    // Queue storage and pointers; mem lands before alu so it drains first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
        end else begin
            if (mem_push_s) begin
                rd_mem_r[tail_r]   <= mem_rd;
                data_mem_r[tail_r] <= mem_data;
            end
            if (alu_push_s) begin
                rd_mem_r[alu_slot_s]   <= alu_rd;
                data_mem_r[alu_slot_s] <= alu_data;
            end
            tail_r  <= tail_r + PTR_W'(push_cnt_s);
            head_r  <= head_r + PTR_W'(pop_s);
            count_r <= count_r + push_cnt_s - CNT_W'(pop_s);
        end
    end

    // Register file write port driven straight from the head entry.
    always_comb begin
        RegWrite   = pop_s;
        write_reg  = '0;
        write_data = '0;
        if (pop_s) begin
            write_reg  = rd_mem_r[head_r];
            write_data = data_mem_r[head_r];
        end else begin
            write_reg  = '0;
            write_data = '0;
        end
    end

    // Walks oldest to newest so the newest matching entry is the one left standing.
    function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] rs);
        logic [DATA_WIDTH:0] res;
        logic [PTR_W-1:0]    idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (rs != '0) && (rd_mem_r[idx] == rs)) begin
                res = {1'b1, data_mem_r[idx]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Forwarding of queued-but-uncommitted results, including the head being written now.
    always_comb begin
        {fwd1_hit, fwd1_data} = fwd_lookup(rs1);
        {fwd2_hit, fwd2_data} = fwd_lookup(rs2);
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized and directed checks of regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd, rs1, rs2;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          RegWrite;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          fwd1_hit, fwd2_hit;
    logic [DW-1:0] fwd1_data, fwd2_data;
    logic [CW-1:0] count;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_lookup(input logic [AW-1:0] rs, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = 32'h0;
        if (rs != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].rd == rs) begin
                    hit  = 1'b1;
                    data = q[i].data;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int            free;
        logic          eh;
        logic [DW-1:0] ed;
        free = DEPTH - q.size();
        check_val("count", 64'(count), 64'(q.size()));
        check_val("mem_ready", 64'(mem_ready), 64'(free >= 1));
        check_val("alu_ready", 64'(alu_ready), 64'(mem_valid ? (free >= 2) : (free >= 1)));
        check_val("RegWrite", 64'(RegWrite), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check_val("write_reg", 64'(write_reg), 64'(q[0].rd));
            check_val("write_data", 64'(write_data), 64'(q[0].data));
        end else begin
            check_val("write_reg_idle", 64'(write_reg), 64'h0);
            check_val("write_data_idle", 64'(write_data), 64'h0);
        end
        model_lookup(rs1, eh, ed);
        check_val("fwd1_hit", 64'(fwd1_hit), 64'(eh));
        check_val("fwd1_data", 64'(fwd1_data), 64'(ed));
        model_lookup(rs2, eh, ed);
        check_val("fwd2_hit", 64'(fwd2_hit), 64'(eh));
        check_val("fwd2_data", 64'(fwd2_data), 64'(ed));
    endtask

    // Next state: head leaves if present, then accepted mem entry, then accepted alu entry.
    task automatic model_update();
        int   free;
        logic macc, aacc;
        free = DEPTH - q.size();
        macc = mem_valid && (free >= 1);
        aacc = alu_valid && (mem_valid ? (free >= 2) : (free >= 1));
        if (q.size() != 0) q.delete(0);
        if (macc && mem_rd != 5'd0) q.push_back({mem_rd, mem_data});
        if (aacc && alu_rd != 5'd0) q.push_back({alu_rd, alu_data});
        if (q.size() > DEPTH) check_val("model_overflow", 64'(q.size()), 64'(DEPTH));
    endtask

    task automatic step(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge clk);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        rs1 = r1; rs2 = r2;
        #1;
        check_outputs();
        model_update();
    endtask

    task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, r2);
    endtask

    initial begin
        reset = 1'b1;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        rs1 = 5'd1; rs2 = 5'd2;
        #1;
        check_val("reset_count", 64'(count), 64'h0);
        check_val("reset_regwrite", 64'(RegWrite), 64'h0);
        check_val("reset_fwd1", 64'(fwd1_hit), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single ALU write into an empty queue.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        check_val("t2_regwrite", 64'(RegWrite), 64'h1);
        check_val("t2_write_reg", 64'(write_reg), 64'd5);
        check_val("t2_write_data", 64'(write_data), 64'hDEADBEEF);
        idle(5'd0, 5'd0);
        check_val("t2_count_back", 64'(count), 64'h0);

        // Same-cycle mem + alu; mem drains first.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0);
        idle(5'd3, 5'd4);
        check_val("t3_first_reg", 64'(write_reg), 64'd3);
        idle(5'd3, 5'd4);
        check_val("t3_second_reg", 64'(write_reg), 64'd4);
        idle(5'd0, 5'd0);

        // Build up to count=3 and hold both sources valid.
        step(1'b1, 5'd8, 32'h100, 1'b1, 5'd9, 32'h101, 5'd0, 5'd0);
        step(1'b1, 5'd10, 32'h102, 1'b1, 5'd11, 32'h103, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'd12, 32'h200 + 32'(i), 1'b1, 5'd13, 32'h300 + 32'(i), 5'd12, 5'd13);
            check_val("t4_mem_ready", 64'(mem_ready), 64'h1);
            check_val("t4_alu_ready", 64'(alu_ready), 64'h0);
        end
        for (int i = 0; i < 4; i++) idle(5'd0, 5'd0);

        // Duplicate rd in flight: newest value forwards, rs2=0 never hits.
        step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 5'd0, 5'd0);
        idle(5'd7, 5'd0);
        check_val("t5_fwd1_hit", 64'(fwd1_hit), 64'h1);
        check_val("t5_fwd1_data", 64'(fwd1_data), 64'hB);
        check_val("t5_fwd2_hit", 64'(fwd2_hit), 64'h0);
        check_val("t5_fwd2_data", 64'(fwd2_data), 64'h0);
        for (int i = 0; i < 2; i++) idle(5'd0, 5'd0);

        // rd=0 request handshakes but is dropped.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        check_val("t6_alu_ready", 64'(alu_ready), 64'h1);
        idle(5'd0, 5'd0);
        check_val("t6_count", 64'(count), 64'h0);
        check_val("t6_regwrite", 64'(RegWrite), 64'h0);

        // Reset mid-drain with three entries queued.
        step(1'b1, 5'd3, 32'h31, 1'b1, 5'd4, 32'h41, 5'd0, 5'd0);
        step(1'b1, 5'd5, 32'h51, 1'b1, 5'd6, 32'h61, 5'd0, 5'd0);
        @(negedge clk);
        mem_valid = 1'b0; alu_valid = 1'b0;
        #1;
        check_val("t1_pre_count", 64'(count), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        check_val("t1_rst_count", 64'(count), 64'h0);
        check_val("t1_rst_regwrite", 64'(RegWrite), 64'h0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) idle(5'd3, 5'd6);

        // Randomized traffic with a small rd range to provoke forwarding collisions.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 5; i++) idle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
